regfile_wb_queue: RTL
=====================

Name: regfile_wb_queue

Overview:
- Write-side initiator for the 64 x 32-bit register file.
- Accepts writeback requests from the execute/memory stages through a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drains one request per cycle onto the register file write port (regwrt, rd, rdval).
- Provides youngest-first bypass of pending values to the rs/rt read side, so decode never reads stale data.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >= 2.
- AW, 6: register address width (64 registers).
- DW, 32: register data width.

Ports:
- in_clk  input  1  sole clock; all state updates on its rising edge.
- in_rst  input  1  asynchronous, active-high reset.
- in_wb_valid  input  1  writeback request present.
- in_wb_rd  input  AW  destination register.
- in_wb_val  input  DW  value to write.
- out_wb_ready  output  1  queue can accept a request this cycle.
- in_drain_en  input  1  permission to issue a write to the register file this cycle.
- in_flush  input  1  synchronous discard of all queued requests.
- out_ctrl_regwrt  output  1  register file write enable (registered).
- out_rd  output  AW  register file write address (registered).
- out_rdval  output  DW  register file write data (registered).
- in_rs  input  AW  read address A under lookup.
- in_rt  input  AW  read address B under lookup.
- out_rs_hit  output  1  a pending write to in_rs exists.
- out_rs_fwd  output  DW  youngest pending value for in_rs; 0 when no hit.
- out_rt_hit  output  1  a pending write to in_rt exists.
- out_rt_fwd  output  DW  youngest pending value for in_rt; 0 when no hit.
- out_count  output  $clog2(DEPTH)+1  occupancy.
- out_empty  output  1  out_count == 0.

Behaviour:
- Reset (in_rst high, asynchronous):
  - Pointers and count go to 0; all FIFO entries become invalid.
  - out_ctrl_regwrt=0, out_rd=0, out_rdval=0.
  - Combinational outputs follow: out_wb_ready=1, out_empty=1, hits=0, fwd=0.
  - Reset mid-operation drops all queued writes; none reach the register file.
- out_wb_ready = (count < DEPTH). No pass-through when full, even if a pop happens the same cycle.
- Push: at an edge with in_wb_valid & out_wb_ready, store {in_wb_rd, in_wb_val} at the tail and increment the tail. When valid is high and ready is low, the producer holds its request.
- Pop: at an edge with in_drain_en and count>0 (count sampled before the edge):
  - Load the head into out_rd/out_rdval.
  - Set out_ctrl_regwrt=1 for exactly one cycle.
  - Advance the head.
- No pop: out_ctrl_regwrt=0; out_rd/out_rdval hold their values.
- Latency: a request accepted at edge N is driven to the register file at edge N+1 at the earliest.
  - A request pushed into an empty queue cannot pop at the same edge.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- Register 0 is an ordinary writable register; no special-casing.
- Duplicate rd entries are allowed and drain in order; the last write wins in the register file.
- Flush:
  - At an edge with in_flush high, count=0, head=tail=0, out_ctrl_regwrt=0.
  - Flush has priority over push and pop in the same cycle.
  - out_rd/out_rdval hold.
- Bypass (combinational):
  - Search the valid FIFO entries from youngest to oldest, then the output stage (match only while out_ctrl_regwrt=1).
  - First match sets hit=1 and fwd=its value. No match gives hit=0, fwd=0.
  - rs and rt lookups are independent and may match the same entry.
  - A request being pushed in the current cycle is not visible until after the edge.

Decomposition:
- Shared package regfile_pkg:
  - NUM_REGS=64, REG_ADDR_W=6, REG_DATA_W=32.
  - Packed typedef wb_req_t {rd, val}, also used by the producer stages.
- One natural sub-module, wb_bypass_match:
  - Combinational priority search over the entry array plus valid mask, given head/tail.
  - Instantiated twice (rs, rt).

Test Plan:
- Reset, then push (rd=3, val=0x0000_0014) with in_drain_en=1 -> edge+1: out_ctrl_regwrt=1, out_rd=3, out_rdval=0x14; the next cycle out_ctrl_regwrt=0, out_empty=1.
- in_drain_en=0, push 4 requests rd=1..4, val=0xA1..0xA4 -> out_count=4, out_wb_ready=0; a fifth valid request is held. Raise drain -> writes emerge in order rd=1..4 on consecutive cycles; ready returns after the first pop.
- Queue holds (rd=5, 0x11) then (rd=5, 0x22); in_rs=5, in_rt=6 -> out_rs_hit=1, out_rs_fwd=0x22, out_rt_hit=0, out_rt_fwd=0.
- Steady state with push and drain every cycle for 10 cycles -> out_count constant at 1; the write sequence matches the push sequence delayed by one cycle; pointers wrap cleanly.
- Three entries queued, assert in_flush together with in_wb_valid and in_drain_en -> next cycle out_count=0, out_ctrl_regwrt=0, no hits; the pushed entry is discarded.
- Two entries queued, pulse in_rst asynchronously between edges -> outputs clear immediately (out_ctrl_regwrt=0, out_rd=0, out_rdval=0, out_count=0), and no write occurs after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Register file constants and the writeback request type.
// The execute and memory stages use the same request type.
package regfile_pkg;
   localparam int NUM_REGS   = 64;
   localparam int REG_ADDR_W = 6;
   localparam int REG_DATA_W = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_DATA_W-1:0] val;
   } wb_req_t;
endpackage

// File: rtl/regfile_wb_queue_if.sv
// Writeback-queue bus: producer handshake, register file write port and bypass lookups.
interface regfile_wb_queue_if
   import regfile_pkg::*;
#(
   parameter int AW = REG_ADDR_W,
   parameter int DW = REG_DATA_W,
   parameter int CW = 3
);
   logic          in_wb_valid;
   logic [AW-1:0] in_wb_rd;
   logic [DW-1:0] in_wb_val;
   logic          out_wb_ready;
   logic          in_drain_en;
   logic          in_flush;
   logic          out_ctrl_regwrt;
   logic [AW-1:0] out_rd;
   logic [DW-1:0] out_rdval;
   logic [AW-1:0] in_rs;
   logic [AW-1:0] in_rt;
   logic          out_rs_hit;
   logic [DW-1:0] out_rs_fwd;
   logic          out_rt_hit;
   logic [DW-1:0] out_rt_fwd;
   logic [CW-1:0] out_count;
   logic          out_empty;

   modport master (
      output in_wb_valid, in_wb_rd, in_wb_val, in_drain_en, in_flush, in_rs, in_rt,
      input  out_wb_ready, out_ctrl_regwrt, out_rd, out_rdval,
             out_rs_hit, out_rs_fwd, out_rt_hit, out_rt_fwd, out_count, out_empty
   );

   modport slave (
      input  in_wb_valid, in_wb_rd, in_wb_val, in_drain_en, in_flush, in_rs, in_rt,
      output out_wb_ready, out_ctrl_regwrt, out_rd, out_rdval,
             out_rs_hit, out_rs_fwd, out_rt_hit, out_rt_fwd, out_count, out_empty
   );
endinterface

// File: rtl/wb_bypass_match.sv
// Priority search of queued writebacks for one read address.
// The youngest matching entry wins.
module wb_bypass_match #(
   parameter int DEPTH = 4,
   parameter int AW    = 6,
   parameter int DW    = 32
) (
   input  logic [DEPTH-1:0][AW-1:0] ent_rd,
   input  logic [DEPTH-1:0][DW-1:0] ent_val,
   input  logic [DEPTH-1:0]         ent_vld,
   input  logic [$clog2(DEPTH)-1:0] head,
   input  logic [AW-1:0]            addr,
   output logic                     hit,
   output logic [DW-1:0]            fwd
);
   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] idx;

   // Walk oldest to youngest from head so that a later match overrides an earlier one.
   always_comb begin
      hit = 1'b0;
      fwd = '0;
      idx = head;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (ent_vld[idx] && (ent_rd[idx] == addr)) begin
            hit = 1'b1;
            fwd = ent_val[idx];
         end
      end
   end
endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback FIFO in front of the register file write port.
// Provides a youngest-first bypass of pending writes to the rs/rt read side.
module regfile_wb_queue
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = REG_ADDR_W,
   parameter int DW    = REG_DATA_W
) (
   input logic               in_clk,
   input logic               in_rst,
   regfile_wb_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0][AW-1:0] ent_rd;
   logic [DEPTH-1:0][DW-1:0] ent_val;
   logic [DEPTH-1:0]         ent_vld;
   logic [PW-1:0]            head;
   logic [PW-1:0]            tail;
   logic [CW-1:0]            count;
   logic                     wrt_q;
   logic [AW-1:0]            rd_q;
   logic [DW-1:0]            val_q;
   logic                     ready;
   logic                     push;
   logic                     pop;

   // Ready depends only on occupancy, so a full queue never passes a request through.
   assign ready = (count < CW'(DEPTH));
   assign push  = bus.in_wb_valid && ready && !bus.in_flush;
   assign pop   = bus.in_drain_en && (count != '0) && !bus.in_flush;

   always_ff @(posedge in_clk) begin
      if (push) begin
         ent_rd[tail]  <= bus.in_wb_rd;
         ent_val[tail] <= bus.in_wb_val;
      end
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         ent_vld <= '0;
         wrt_q   <= 1'b0;
         rd_q    <= '0;
         val_q   <= '0;
      end else if (bus.in_flush) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         ent_vld <= '0;
         wrt_q   <= 1'b0;
      end else begin
         wrt_q <= pop;
         if (push) begin
            ent_vld[tail] <= 1'b1;
            tail          <= tail + PW'(1);
         end
         if (pop) begin
            ent_vld[head] <= 1'b0;
            head          <= head + PW'(1);
            rd_q          <= ent_rd[head];
            val_q         <= ent_val[head];
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   logic          rs_q_hit, rt_q_hit;
   logic [DW-1:0] rs_q_fwd, rt_q_fwd;
   logic          rs_stg, rt_stg;

   wb_bypass_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_rs_match (
      .ent_rd (ent_rd),
      .ent_val(ent_val),
      .ent_vld(ent_vld),
      .head   (head),
      .addr   (bus.in_rs),
      .hit    (rs_q_hit),
      .fwd    (rs_q_fwd)
   );

   wb_bypass_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_rt_match (
      .ent_rd (ent_rd),
      .ent_val(ent_val),
      .ent_vld(ent_vld),
      .head   (head),
      .addr   (bus.in_rt),
      .hit    (rt_q_hit),
      .fwd    (rt_q_fwd)
   );

   // The output stage is older than any queued entry, so it only answers when the queue misses.
   assign rs_stg = wrt_q && (rd_q == bus.in_rs);
   assign rt_stg = wrt_q && (rd_q == bus.in_rt);

   assign bus.out_rs_hit      = rs_q_hit || rs_stg;
   assign bus.out_rs_fwd      = rs_q_hit ? rs_q_fwd : (rs_stg ? val_q : '0);
   assign bus.out_rt_hit      = rt_q_hit || rt_stg;
   assign bus.out_rt_fwd      = rt_q_hit ? rt_q_fwd : (rt_stg ? val_q : '0);
   assign bus.out_wb_ready    = ready;
   assign bus.out_ctrl_regwrt = wrt_q;
   assign bus.out_rd          = rd_q;
   assign bus.out_rdval       = val_q;
   assign bus.out_count       = count;
   assign bus.out_empty       = (count == '0);
endmodule
